// File: rtl/mul_seq_unit_if.sv
// Operand/result handshake bundle for the sequential multiplier.
// master = issuing stage, slave = multiplier.
interface mul_seq_unit_if #(
  parameter int WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in1;
  logic [WIDTH-1:0]     in2;
  logic [1:0]           in_mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out;

  modport master (
    output in_valid, in1, in2, in_mode, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, in1, in2, in_mode, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/mul_seq_unit.sv
// Sequential WIDTHxWIDTH multiplier: STEP multiplier bits per cycle into carry-save sum/carry, one resolve cycle.
// Result WIDTH/STEP+1 cycles after accept (zero operand: next cycle); held until out_ready, no accept meanwhile.
module mul_seq_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_flush,
  mul_seq_unit_if.slave bus
);
  localparam int N  = WIDTH / STEP;
  localparam int CW = $clog2(N) + 1;
  localparam int PW = 2 * WIDTH;

  if ((WIDTH % STEP) != 0 || (WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_params
    $error("mul_seq_unit: WIDTH must be even, >= 4 and a multiple of STEP");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]    r_sum;
  logic [PW-1:0]    r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_neg;
  logic [PW-1:0]    r_out;
  logic             r_out_valid;

  logic             w_accept;
  logic             w_zero;
  logic             w_sgn1;
  logic             w_sgn2;
  logic [WIDTH-1:0] w_mag1;
  logic [WIDTH-1:0] w_mag2;
  logic [PW-1:0]    w_sum_nxt;
  logic [PW-1:0]    w_carry_nxt;
  logic [PW-1:0]    w_pp;
  logic [PW-1:0]    w_tmp;
  logic [PW-1:0]    w_prod;

  assign bus.in_ready  = (r_state == S_IDLE) & ~i_flush & ~i_rst;
  assign bus.out_valid = r_out_valid;
  assign bus.out       = r_out;

  assign w_accept = bus.in_valid & bus.in_ready;
  assign w_zero   = (bus.in1 == '0) | (bus.in2 == '0);
  assign w_sgn1   = bus.in_mode[0] & bus.in1[WIDTH-1];
  assign w_sgn2   = bus.in_mode[1] & bus.in2[WIDTH-1];
  // Negating the most negative value wraps back onto itself, which is the correct unsigned magnitude.
  assign w_mag1   = w_sgn1 ? -bus.in1 : bus.in1;
  assign w_mag2   = w_sgn2 ? -bus.in2 : bus.in2;
  assign w_prod   = r_sum + r_carry;

  // One 3:2 compressor row per retired multiplier bit; r_mcand is already aligned to the current bit group.
  always_comb begin
    w_sum_nxt   = r_sum;
    w_carry_nxt = r_carry;
    w_pp        = '0;
    w_tmp       = '0;
    for (int j = 0; j < STEP; j++) begin
      w_pp        = r_mplier[j] ? (r_mcand << j) : '0;
      w_tmp       = w_sum_nxt ^ w_carry_nxt ^ w_pp;
      w_carry_nxt = ((w_sum_nxt & w_carry_nxt) | (w_sum_nxt & w_pp) | (w_carry_nxt & w_pp)) << 1;
      w_sum_nxt   = w_tmp;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_zero ? S_DONE : S_BUSY;
      S_BUSY:  if (r_cnt == CW'(N - 1)) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_sum       <= '0;
      r_carry     <= '0;
      r_cnt       <= '0;
      r_neg       <= 1'b0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_mag1};
            r_mplier <= w_mag2;
            r_neg    <= w_sgn1 ^ w_sgn2;
            r_sum    <= '0;
            r_carry  <= '0;
            r_cnt    <= '0;
            if (w_zero) begin
              r_out       <= '0;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_BUSY: begin
          r_sum    <= w_sum_nxt;
          r_carry  <= w_carry_nxt;
          r_mcand  <= r_mcand << STEP;
          r_mplier <= r_mplier >> STEP;
          r_cnt    <= r_cnt + 1'b1;
        end
        S_FIX: begin
          r_out       <= r_neg ? -w_prod : w_prod;
          r_out_valid <= 1'b1;
        end
        S_DONE: begin
          if (bus.out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
